// File: rtl/dcp_pkg.sv
// Shared definitions for the serial debug control panel: command characters,
// print characters, SCAN/PRINT type encodings and the child-engine state enum.
package dcp_pkg;

   localparam logic [7:0] CMD_D      = 8'h44;
   localparam logic [7:0] CMD_I      = 8'h49;
   localparam logic [7:0] CMD_T      = 8'h54;

   localparam logic [7:0] CHAR_COLON = 8'h3A;
   localparam logic [7:0] CHAR_NL    = 8'h0A;

   localparam logic       TYPE_CHAR  = 1'b0;
   localparam logic       TYPE_HEX   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARG,
      ST_RD,
      ST_TX_A,
      ST_TX_C,
      ST_TX_D,
      ST_TX_N,
      ST_DONE
   } dcp_state_e;

   function automatic logic is_print(dcp_state_e s);
      return (s == ST_TX_A) || (s == ST_TX_C) || (s == ST_TX_D) || (s == ST_TX_N);
   endfunction

endpackage

// File: rtl/dcp_tx_seq.sv
// Single-request PRINT handshake holder: load a payload, hold req until ack,
// then release. clr_i drops an outstanding request without waiting for ack.
module dcp_tx_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        clr_i,
   input  logic        type_i,
   input  logic [31:0] data_i,
   input  logic        ack_i,
   output logic        req_o,
   output logic        type_o,
   output logic [31:0] dout_o
);

   logic        req_q;
   logic        type_q;
   logic [31:0] dout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q  <= 1'b0;
         type_q <= 1'b0;
         dout_q <= '0;
      end else if (clr_i) begin
         req_q  <= 1'b0;
      end else if (load_i) begin
         req_q  <= 1'b1;
         type_q <= type_i;
         dout_q <= data_i;
      end else if (ack_i && req_q) begin
         req_q  <= 1'b0;
      end
   end

   assign req_o  = req_q;
   assign type_o = type_q;
   assign dout_o = dout_q;

endmodule

// File: rtl/dcp_dump_engine.sv
// Multi-channel memory dump child engine: takes an optional hex start address
// and prints WORDS lines of "AAAAAAAA:DDDDDDDD\n" from the selected memory.
module dcp_dump_engine
   import dcp_pkg::*;
#(
   parameter int             CH        = 2,
   parameter logic [CH*8-1:0] CMD_CODES = {8'h49, 8'h44},
   parameter int             WORDS     = 8,
   parameter int             ADDR_W    = 32,
   parameter int             RD_LAT    = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [7:0]                          sel_mode,
   output logic                                finish,
   output logic                                req_rx,
   output logic                                type_rx,
   input  logic [31:0]                         din_rx,
   input  logic                                flag_rx,
   input  logic                                ack_rx,
   output logic                                req_tx,
   output logic                                type_tx,
   output logic [31:0]                         dout_tx,
   input  logic                                ack_tx,
   output logic [ADDR_W-1:0]                   addr,
   output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ch_sel,
   input  logic [CH*32-1:0]                    dout_mem
);

   localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
   localparam int CNT_W = $clog2(WORDS + 1);

   dcp_state_e        state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] nxt_q [CH];
   logic              nxt_we;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        lat_q, lat_d;
   logic [31:0]       data_q, data_d;
   logic              first_q;

   logic              hit;
   logic [CH_W-1:0]   hit_ch;
   logic [7:0]        cur_code;
   logic              match;
   logic [31:0]       mem_word;
   logic              tx_ack;
   logic              tx_load;
   logic              tx_clr;
   logic              tx_type;
   logic [31:0]       tx_data;

   // Descending scan so the lowest matching channel index wins.
   always_comb begin
      hit    = 1'b0;
      hit_ch = '0;
      for (int k = CH - 1; k >= 0; k--) begin
         if (sel_mode == CMD_CODES[8*k +: 8]) begin
            hit    = 1'b1;
            hit_ch = CH_W'(k);
         end
      end
   end

   assign cur_code = CMD_CODES[{ch_q, 3'b000} +: 8];
   assign match    = (sel_mode == cur_code);
   assign mem_word = dout_mem[{ch_q, 5'b00000} +: 32];
   assign tx_ack   = ack_tx & req_tx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         lat_q   <= '0;
         first_q <= 1'b0;
         for (int k = 0; k < CH; k++) nxt_q[k] <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         first_q <= is_print(state_d) && (state_d != state_q);
         if (nxt_we) nxt_q[ch_q] <= addr_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      lat_d   = '0;
      data_d  = data_q;
      nxt_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hit) begin
               ch_d    = hit_ch;
               state_d = ST_ARG;
            end
         end
         ST_ARG: begin
            if (!match) begin
               state_d = ST_IDLE;
            end else if (ack_rx) begin
               addr_d  = flag_rx ? (din_rx[ADDR_W-1:0] & ~ADDR_W'(3)) : nxt_q[ch_q];
               cnt_d   = '0;
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            if (!match) begin
               state_d = ST_IDLE;
            end else if (lat_q == 2'(RD_LAT)) begin
               data_d  = mem_word;
               state_d = ST_TX_A;
            end else begin
               lat_d   = lat_q + 2'd1;
            end
         end
         ST_TX_A: begin
            if (!match)      state_d = ST_IDLE;
            else if (tx_ack) state_d = ST_TX_C;
         end
         ST_TX_C: begin
            if (!match)      state_d = ST_IDLE;
            else if (tx_ack) state_d = ST_TX_D;
         end
         ST_TX_D: begin
            if (!match)      state_d = ST_IDLE;
            else if (tx_ack) state_d = ST_TX_N;
         end
         ST_TX_N: begin
            if (!match) begin
               state_d = ST_IDLE;
            end else if (tx_ack) begin
               addr_d = addr_q + ADDR_W'(4);
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WORDS - 1)) begin
                  state_d = ST_DONE;
                  nxt_we  = 1'b1;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_DONE: begin
            if (!match) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A print state loads its payload in its first cycle, so req_tx is low
   // for one cycle between consecutive handshakes.
   always_comb begin
      req_rx  = (state_q == ST_ARG);
      type_rx = (state_q == ST_ARG) ? TYPE_HEX : TYPE_CHAR;
      finish  = (state_q == ST_DONE);
      tx_type = TYPE_CHAR;
      tx_data = '0;
      case (state_q)
         ST_TX_A: begin
            tx_type = TYPE_HEX;
            tx_data = 32'(addr_q);
         end
         ST_TX_C: tx_data = {24'd0, CHAR_COLON};
         ST_TX_D: begin
            tx_type = TYPE_HEX;
            tx_data = data_q;
         end
         ST_TX_N: tx_data = {24'd0, CHAR_NL};
         default: ;
      endcase
      tx_load = first_q && is_print(state_q) && match;
      tx_clr  = (state_q != ST_IDLE) && !match;
   end

   assign addr   = addr_q;
   assign ch_sel = ch_q;

   dcp_tx_seq u_tx (
      .clk    (clk),
      .rst    (rst),
      .load_i (tx_load),
      .clr_i  (tx_clr),
      .type_i (tx_type),
      .data_i (tx_data),
      .ack_i  (ack_tx),
      .req_o  (req_tx),
      .type_o (type_tx),
      .dout_o (dout_tx)
   );

endmodule
